// File: rtl/nes_controller_emulator.sv
// Pad-side NES serial responder: synchronises the console's latch/clock pins, debounces the
// buttons, applies turbo on A/B and shifts the result out active-low on nes_data.
module nes_controller_emulator #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TURBO_POLLS     = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons_raw,
  input  logic [1:0] turbo_en,
  input  logic       nes_latch,
  input  logic       nes_clk,
  output logic       nes_data,
  output logic [7:0] buttons_db,
  output logic       poll_done,
  output logic       busy
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned TpW = $clog2(TURBO_POLLS) + 1;
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, clk_sync_q;
  logic             latch_prev_q, clk_prev_q;
  logic [7:0]       btn_sync_q [SYNC_STAGES];
  logic [DbW-1:0]   db_cnt_q [8];
  logic [7:0]       buttons_db_q;
  logic [TpW-1:0]   turbo_cnt_q;
  logic             turbo_phase_q;
  logic [7:0]       sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [ToW-1:0]   timeout_q, timeout_d;
  logic             nes_data_q, nes_data_d;
  logic             poll_done_q, poll_done_d;
  logic             latch_sync, clk_sync, latch_fall, clk_rise;
  logic [7:0]       btn_synced, eff;

  assign latch_sync = latch_sync_q[SYNC_STAGES-1];
  assign clk_sync   = clk_sync_q[SYNC_STAGES-1];
  assign btn_synced = btn_sync_q[SYNC_STAGES-1];
  assign latch_fall = ~latch_sync & latch_prev_q;
  assign clk_rise   = clk_sync & ~clk_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '0;
      latch_prev_q <= 1'b0;
      clk_prev_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) btn_sync_q[i] <= '0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], nes_latch};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], nes_clk};
      latch_prev_q <= latch_sync;
      clk_prev_q   <= clk_sync;
      btn_sync_q[0] <= buttons_raw;
      for (int i = 1; i < SYNC_STAGES; i++) btn_sync_q[i] <= btn_sync_q[i-1];
    end
  end

  // Per-button debounce: a change must persist DEBOUNCE_CYCLES cycles to be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      buttons_db_q <= '0;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (btn_synced[i] == buttons_db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          buttons_db_q[i] <= btn_synced[i];
          db_cnt_q[i]     <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b0;
    end else if (poll_done_q) begin
      if (turbo_cnt_q == TpW'(TURBO_POLLS - 1)) begin
        turbo_cnt_q   <= '0;
        turbo_phase_q <= ~turbo_phase_q;
      end else begin
        turbo_cnt_q <= turbo_cnt_q + TpW'(1);
      end
    end
  end

  always_comb begin
    eff    = buttons_db_q;
    eff[0] = buttons_db_q[0] & (~turbo_en[0] | turbo_phase_q);
    eff[1] = buttons_db_q[1] & (~turbo_en[1] | turbo_phase_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      timeout_q   <= '0;
      nes_data_q  <= 1'b1;
      poll_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      timeout_q   <= timeout_d;
      nes_data_q  <= nes_data_d;
      poll_done_q <= poll_done_d;
    end
  end

  // Latch level wins over everything, including a coincident clock edge.
  always_comb begin
    state_d = state_q;
    if (latch_sync) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StLoad:  if (latch_fall) state_d = StShift;
        StShift: begin
          if (clk_rise && bit_cnt_q == 4'd7) begin
            state_d = StDone;
          end else if (!clk_rise && timeout_q == ToW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    timeout_d   = '0;
    nes_data_d  = nes_data_q;
    poll_done_d = 1'b0;
    unique case (state_d)
      StIdle: nes_data_d = 1'b1;
      StLoad: begin
        sr_d       = eff;
        bit_cnt_d  = '0;
        nes_data_d = ~eff[0];
      end
      StShift: begin
        if (state_q != StShift) begin
          bit_cnt_d  = '0;
          nes_data_d = ~sr_q[0];
        end else if (clk_rise) begin
          sr_d       = sr_q >> 1;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          nes_data_d = ~sr_q[1];
        end else begin
          timeout_d = timeout_q + ToW'(1);
        end
      end
      StDone: begin
        // After the 8th bit the line reads as pressed ("1" to software) like an official pad.
        nes_data_d = 1'b0;
        if (state_q == StShift) begin
          sr_d        = sr_q >> 1;
          bit_cnt_d   = 4'd8;
          poll_done_d = 1'b1;
        end
      end
      default: nes_data_d = 1'b1;
    endcase
  end

  assign nes_data   = nes_data_q;
  assign poll_done  = poll_done_q;
  assign buttons_db = buttons_db_q;
  assign busy       = (state_q == StLoad) || (state_q == StShift);

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Scoreboarded bench: stimulus drives pad pins and queues expected nes_data transitions;
// a monitor checks each transition at the fixed pin-to-output latency.
module tb_nes_controller_emulator;

  localparam int S  = 2;
  localparam int D  = 16;
  localparam int TP = 2;
  localparam int TO = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buttons_raw;
  logic [1:0] turbo_en;
  logic       nes_latch;
  logic       nes_clk;
  logic       nes_data;
  logic [7:0] buttons_db;
  logic       poll_done;
  logic       busy;

  nes_controller_emulator #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .TURBO_POLLS    (TP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons_raw(buttons_raw),
    .turbo_en   (turbo_en),
    .nes_latch  (nes_latch),
    .nes_clk    (nes_clk),
    .nes_data   (nes_data),
    .buttons_db (buttons_db),
    .poll_done  (poll_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  event pin_ev;
  bit exp_old_q[$];
  bit exp_new_q[$];
  int pd_count = 0;

  // Reference model: polls are an index into a captured button vector.
  typedef enum int {MIdle, MLoad, MShift, MDone} mstate_e;
  mstate_e    m_state;
  logic [7:0] m_btn;
  logic [7:0] m_cap;
  logic [1:0] m_turbo;
  int         m_bit;
  int         m_polls;
  int         m_total_done;
  bit         m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_eff();
    logic [7:0] e;
    bit phase;
    phase = ((m_polls / TP) % 2) == 1;
    e = m_btn;
    if (m_turbo[0] && !phase) e[0] = 1'b0;
    if (m_turbo[1] && !phase) e[1] = 1'b0;
    return e;
  endfunction

  task automatic pin(input logic l, input logic c);
    bit old;
    logic pl, pc;
    @(negedge clk);
    old = m_data;
    pl = nes_latch;
    pc = nes_clk;
    nes_latch = l;
    nes_clk   = c;
    if (l) begin
      m_cap = model_eff();
      m_bit = 0;
      m_state = MLoad;
      m_data = ~m_cap[0];
    end else if (pl && m_state == MLoad) begin
      m_state = MShift;
      m_data = ~m_cap[0];
    end else if (c && !pc && m_state == MShift) begin
      m_bit++;
      if (m_bit == 8) begin
        m_state = MDone;
        m_data = 1'b0;
        m_polls++;
        m_total_done++;
      end else begin
        m_data = ~m_cap[m_bit];
      end
    end
    exp_old_q.push_back(old);
    exp_new_q.push_back(m_data);
    -> pin_ev;
    repeat (6) @(negedge clk);
  endtask

  task automatic full_poll(input int n_clk, input bit chg, input logic [7:0] nb);
    pin(1'b1, 1'b0);
    pin(1'b0, 1'b0);
    if (chg) begin
      buttons_raw = nb;
      m_btn = nb;
    end
    for (int k = 0; k < n_clk; k++) begin
      pin(1'b0, 1'b1);
      pin(1'b0, 1'b0);
    end
    check("poll_done_count", pd_count, m_total_done);
  endtask

  task automatic set_buttons(input logic [7:0] b);
    @(negedge clk);
    buttons_raw = b;
    m_btn = b;
    repeat (30) @(negedge clk);
    check("buttons_db_settled", buttons_db, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_nes_data", nes_data, 1);
    check("reset_busy", busy, 0);
    check("reset_buttons_db", buttons_db, 0);
    reset = 1'b0;
    m_state = MIdle;
    m_data = 1'b1;
    m_polls = 0;
    repeat (30) @(negedge clk);
    check("post_reset_db", buttons_db, m_btn);
  endtask

  // Monitor: value must be old after S edges and new after S+1 edges.
  initial begin
    bit o, n;
    forever begin
      @(pin_ev);
      if (exp_new_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        o = exp_old_q.pop_front();
        n = exp_new_q.pop_front();
        repeat (S) @(posedge clk);
        @(negedge clk);
        check("nes_data_before_latency", nes_data, o);
        @(posedge clk);
        @(negedge clk);
        check("nes_data_after_latency", nes_data, n);
      end
    end
  end

  initial begin
    bit pd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (poll_done) begin
        pd_count++;
        check("poll_done_width", pd_prev, 0);
      end
      pd_prev = poll_done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nb;
    reset = 1'b1;
    buttons_raw = '0;
    turbo_en = '0;
    nes_latch = 1'b0;
    nes_clk = 1'b0;
    m_state = MIdle;
    m_btn = '0;
    m_cap = '0;
    m_turbo = '0;
    m_bit = 0;
    m_polls = 0;
    m_total_done = 0;
    m_data = 1'b1;
    repeat (3) @(negedge clk);
    check("init_nes_data", nes_data, 1);
    check("init_buttons_db", buttons_db, 0);
    check("init_poll_done", poll_done, 0);
    check("init_busy", busy, 0);
    reset = 1'b0;

    // A + Start
    set_buttons(8'b0000_1001);
    full_poll(8, 1'b0, 8'h00);
    check("data_after_poll", nes_data, 0);

    // Debounce: short glitch rejected, held change accepted at S+D cycles
    @(negedge clk);
    buttons_raw[4] = 1'b1;
    repeat (5) @(negedge clk);
    buttons_raw[4] = 1'b0;
    repeat (25) @(negedge clk);
    check("glitch_rejected", buttons_db, 8'b0000_1001);
    buttons_raw[4] = 1'b1;
    repeat (S + D - 1) @(negedge clk);
    check("debounce_early", buttons_db[4], 0);
    @(negedge clk);
    check("debounce_exact", buttons_db[4], 1);
    m_btn = buttons_raw;

    // Turbo on A from a clean phase
    do_reset();
    turbo_en = 2'b01;
    m_turbo = 2'b01;
    set_buttons(8'h01);
    for (int p = 0; p < 6; p++) full_poll(8, 1'b0, 8'h00);

    // Abandoned poll times out
    pin(1'b1, 1'b0);
    pin(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      pin(1'b0, 1'b1);
      pin(1'b0, 1'b0);
    end
    repeat (TO + 50) @(negedge clk);
    m_state = MIdle;
    m_data = 1'b1;
    check("timeout_nes_data", nes_data, 1);
    check("timeout_busy", busy, 0);
    check("timeout_no_done", pd_count, m_total_done);
    pin(1'b0, 1'b1);
    pin(1'b0, 1'b0);
    full_poll(8, 1'b0, 8'h00);

    // Latch and clock rise together mid-shift
    turbo_en = 2'b00;
    m_turbo = 2'b00;
    set_buttons(8'hA5);
    pin(1'b1, 1'b0);
    pin(1'b0, 1'b0);
    pin(1'b0, 1'b1);
    pin(1'b0, 1'b0);
    pin(1'b1, 1'b1);
    check("coincident_busy", busy, 1);
    pin(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      pin(1'b0, 1'b1);
      pin(1'b0, 1'b0);
    end

    // Reset mid-poll, then a clean poll
    set_buttons(8'h3C);
    pin(1'b1, 1'b0);
    pin(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      pin(1'b0, 1'b1);
      pin(1'b0, 1'b0);
    end
    do_reset();
    full_poll(8, 1'b0, 8'h00);

    // Randomised polls with mid-shift button changes and over-reads
    for (int it = 0; it < 12; it++) begin
      m_turbo = 2'($urandom_range(0, 3));
      turbo_en = m_turbo;
      set_buttons(8'($urandom));
      nb = 8'($urandom);
      full_poll($urandom_range(8, 10), 1'b1, nb);
      repeat (30) @(negedge clk);
      check("rand_db", buttons_db, m_btn);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_new_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
